// File: rtl/chip8_fb_pkg.sv
// Shared definitions for the Chip-8/SCHIP framebuffer writer: geometry,
// blitter FSM states and the lores pixel-doubling helper.
package chip8_fb_pkg;

  localparam int FB_WORDS_PER_ROW = 8;
  localparam int FB_ROWS          = 64;
  localparam int FB_AW            = 9;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FETCH0,
    ST_FETCH1,
    ST_FETCH2,
    ST_RD0,
    ST_RD1,
    ST_WR0,
    ST_WR1,
    ST_LINE,
    ST_FINISH
  } blit_state_e;

  function automatic logic [15:0] lores_double(input logic [7:0] b);
    logic [15:0] d;
    d = '0;
    for (int k = 0; k < 8; k++) begin
      d[2*k]   = b[k];
      d[2*k+1] = b[k];
    end
    return d;
  endfunction

endpackage

// File: rtl/sprite_shifter.sv
// Aligns a 16-pixel sprite row to its framebuffer position, splitting it
// across the target word and the word to its right.
module sprite_shifter (
  input  logic [15:0] pat,
  input  logic [3:0]  shift,
  input  logic        clip,
  output logic [15:0] hi,
  output logic [15:0] lo
);

  logic [31:0] sh;

  assign sh = {pat, 16'h0000} >> shift;
  assign hi = sh[31:16];
  assign lo = clip ? 16'h0000 : sh[15:0];

endmodule

// File: rtl/sprite_blitter.sv
// Executes DRW/CLS against port B of the 128x64 framebuffer, XOR-drawing
// sprite rows fetched from main memory and reporting the VF collision flag.
module sprite_blitter
  import chip8_fb_pkg::*;
#(
  parameter int SPR_AW = 12,
  parameter int FB_AW  = 9
) (
  input  logic              clk,
  input  logic              res,
  input  logic              hires,
  input  logic              start_draw,
  input  logic              start_clear,
  input  logic [6:0]        x_in,
  input  logic [5:0]        y_in,
  input  logic [3:0]        n_in,
  input  logic [SPR_AW-1:0] i_in,
  output logic              busy,
  output logic              done,
  output logic              collision,
  output logic [SPR_AW-1:0] spr_addr,
  output logic              spr_rd,
  input  logic [7:0]        spr_data,
  output logic [FB_AW-1:0]  fb_addr,
  output logic              fb_we,
  output logic [15:0]       fb_wdata,
  input  logic [15:0]       fb_rdata
);

  blit_state_e state;

  logic        lores_q;
  logic        wide_q;
  logic        line_sel;
  logic [6:0]  px;
  logic [5:0]  line;
  logic [4:0]  row;
  logic [4:0]  nrows;
  logic [7:0]  byte0;
  logic [7:0]  byte1;

  logic [15:0] pat;
  logic [15:0] hi_word;
  logic [15:0] lo_word;
  logic [2:0]  w;
  logic [2:0]  w1;
  logic        clip;
  logic [6:0]  next_line;

  logic [6:0]  acc_px;
  logic [5:0]  acc_py;
  logic [4:0]  acc_rows;
  logic        acc_wide;

  assign w         = px[6:4];
  assign w1        = w + 3'd1;
  assign clip      = (w == 3'd7);
  assign next_line = {1'b0, line} + 7'd1;

  always_comb begin
    acc_wide = hires && (n_in == 4'd0);
    acc_px   = hires ? x_in : {x_in[5:0], 1'b0};
    acc_py   = hires ? y_in : {y_in[4:0], 1'b0};
    acc_rows = acc_wide ? 5'd16 : {1'b0, n_in};
  end

  always_comb begin
    pat = {byte0, 8'h00};
    if (wide_q)
      pat = {byte0, byte1};
    else if (lores_q)
      pat = lores_double(byte0);
  end

  sprite_shifter u_shifter (
    .pat   (pat),
    .shift (px[3:0]),
    .clip  (clip),
    .hi    (hi_word),
    .lo    (lo_word)
  );

  // Outputs are registered, so each transition loads the values the
  // destination state must present during its own cycle.
  always_ff @(posedge clk) begin
    if (res) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      collision <= 1'b0;
      spr_rd    <= 1'b0;
      spr_addr  <= '0;
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_wdata  <= '0;
      lores_q   <= 1'b0;
      wide_q    <= 1'b0;
      line_sel  <= 1'b0;
      px        <= '0;
      line      <= '0;
      row       <= '0;
      nrows     <= '0;
      byte0     <= '0;
      byte1     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start_draw) begin
            lores_q   <= !hires;
            wide_q    <= acc_wide;
            px        <= acc_px;
            line      <= acc_py;
            nrows     <= acc_rows;
            row       <= '0;
            line_sel  <= 1'b0;
            collision <= 1'b0;
            busy      <= 1'b1;
            if (acc_rows == 5'd0) begin
              done  <= 1'b1;
              state <= ST_FINISH;
            end else begin
              spr_rd   <= 1'b1;
              spr_addr <= i_in;
              state    <= ST_FETCH0;
            end
          end else if (start_clear) begin
            busy     <= 1'b1;
            fb_addr  <= '0;
            fb_wdata <= '0;
            fb_we    <= 1'b1;
            state    <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (fb_addr == {FB_AW{1'b1}}) begin
            fb_we <= 1'b0;
            done  <= 1'b1;
            state <= ST_FINISH;
          end else begin
            fb_addr <= fb_addr + 1'b1;
          end
        end
        ST_FETCH0: begin
          spr_rd <= wide_q;
          if (wide_q)
            spr_addr <= spr_addr + 1'b1;
          state <= ST_FETCH1;
        end
        ST_FETCH1: begin
          byte0  <= spr_data;
          spr_rd <= 1'b0;
          if (wide_q) begin
            state <= ST_FETCH2;
          end else begin
            fb_addr <= {line, w};
            state   <= ST_RD0;
          end
        end
        ST_FETCH2: begin
          byte1   <= spr_data;
          fb_addr <= {line, w};
          state   <= ST_RD0;
        end
        ST_RD0: begin
          fb_addr <= {line, w1};
          state   <= ST_RD1;
        end
        ST_RD1: begin
          fb_addr   <= {line, w};
          fb_we     <= 1'b1;
          fb_wdata  <= fb_rdata ^ hi_word;
          collision <= collision | (|(fb_rdata & hi_word));
          state     <= ST_WR0;
        end
        ST_WR0: begin
          if (clip) begin
            fb_we <= 1'b0;
            state <= ST_LINE;
          end else begin
            fb_addr   <= {line, w1};
            fb_wdata  <= fb_rdata ^ lo_word;
            collision <= collision | (|(fb_rdata & lo_word));
            state     <= ST_WR1;
          end
        end
        ST_WR1: begin
          fb_we <= 1'b0;
          state <= ST_LINE;
        end
        ST_LINE: begin
          // Lines only ever advance by one, so a target past the bottom
          // edge means every remaining row is clipped too.
          line <= next_line[5:0];
          if (lores_q && !line_sel) begin
            line_sel <= 1'b1;
            fb_addr  <= {next_line[5:0], w};
            state    <= ST_RD0;
          end else if ((row + 5'd1 == nrows) || next_line[6]) begin
            done  <= 1'b1;
            state <= ST_FINISH;
          end else begin
            line_sel <= 1'b0;
            row      <= row + 5'd1;
            spr_rd   <= 1'b1;
            spr_addr <= spr_addr + 1'b1;
            state    <= ST_FETCH0;
          end
        end
        ST_FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: a pixel-level framebuffer model
// predicts every port-B write, which is popped and compared as the DUT writes.
module tb_sprite_blitter;

  localparam int SPR_AW = 12;
  localparam int FB_AW  = 9;

  logic              clk = 1'b0;
  logic              res;
  logic              hires;
  logic              start_draw;
  logic              start_clear;
  logic [6:0]        x_in;
  logic [5:0]        y_in;
  logic [3:0]        n_in;
  logic [SPR_AW-1:0] i_in;
  logic              busy;
  logic              done;
  logic              collision;
  logic [SPR_AW-1:0] spr_addr;
  logic              spr_rd;
  logic [7:0]        spr_data;
  logic [FB_AW-1:0]  fb_addr;
  logic              fb_we;
  logic [15:0]       fb_wdata;
  logic [15:0]       fb_rdata;

  always #5 clk = ~clk;

  sprite_blitter #(.SPR_AW(SPR_AW), .FB_AW(FB_AW)) dut (
    .clk         (clk),
    .res         (res),
    .hires       (hires),
    .start_draw  (start_draw),
    .start_clear (start_clear),
    .x_in        (x_in),
    .y_in        (y_in),
    .n_in        (n_in),
    .i_in        (i_in),
    .busy        (busy),
    .done        (done),
    .collision   (collision),
    .spr_addr    (spr_addr),
    .spr_rd      (spr_rd),
    .spr_data    (spr_data),
    .fb_addr     (fb_addr),
    .fb_we       (fb_we),
    .fb_wdata    (fb_wdata),
    .fb_rdata    (fb_rdata)
  );

  typedef struct {
    int          addr;
    logic [15:0] data;
  } wr_t;

  logic [15:0] fb_mem   [512];
  logic [15:0] model_fb [512];
  logic [7:0]  spr_mem  [4096];
  logic        fill_en  = 1'b0;
  logic [15:0] fill_val = 16'h0000;
  wr_t         exp_q [$];
  wr_t         mon_e;
  logic        exp_coll = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cycle = 0;
  int          last_wr_cycle = 0;
  int          done_cycle = 0;

  // Framebuffer port B and sprite memory, both with one cycle of read latency
  always @(posedge clk) begin
    if (fill_en) begin
      for (int a = 0; a < 512; a++) fb_mem[a] <= fill_val;
    end else if (fb_we) begin
      fb_mem[fb_addr] <= fb_wdata;
    end
    fb_rdata <= fb_mem[fb_addr];
    spr_data <= spr_rd ? spr_mem[spr_addr] : 8'($urandom);
    cycle    <= cycle + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (!res && fb_we) begin
      last_wr_cycle = cycle;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("wr_addr", 32'(fb_addr), 32'(mon_e.addr));
        checkOutput("wr_data", 32'(fb_wdata), 32'(mon_e.data));
      end
    end
  end

  task automatic fill_fb(input logic [15:0] val);
    @(negedge clk);
    fill_val = val;
    fill_en  = 1'b1;
    @(negedge clk);
    fill_en  = 1'b0;
    for (int a = 0; a < 512; a++) model_fb[a] = val;
  endtask

  task automatic model_clear();
    for (int a = 0; a < 512; a++) begin
      model_fb[a] = 16'h0000;
      exp_q.push_back('{addr: a, data: 16'h0000});
    end
  endtask

  task automatic model_draw(input bit hr, input int x, input int y, input int n, input int i);
    int px, py, rows, width, nlines, line, col, wd, bt;
    logic [7:0] b;
    logic on;
    exp_coll = 1'b0;
    px     = hr ? x % 128 : 2 * (x % 64);
    py     = hr ? y % 64 : 2 * (y % 32);
    width  = (hr && n == 0) ? 16 : 8;
    rows   = (hr && n == 0) ? 16 : n;
    nlines = hr ? 1 : 2;
    for (int r = 0; r < rows; r++) begin
      for (int ls = 0; ls < nlines; ls++) begin
        line = hr ? py + r : py + 2 * r + ls;
        if (line < 64) begin
          for (int j = 0; j < width; j++) begin
            if (width == 16) b = spr_mem[(i + 2 * r + j / 8) % 4096];
            else             b = spr_mem[(i + r) % 4096];
            on = b[7 - (j % 8)];
            for (int d = 0; d < nlines; d++) begin
              col = hr ? px + j : px + 2 * j + d;
              if (on && col < 128) begin
                wd = line * 8 + col / 16;
                bt = 15 - col % 16;
                if (model_fb[wd][bt]) exp_coll = 1'b1;
                model_fb[wd][bt] = ~model_fb[wd][bt];
              end
            end
          end
          exp_q.push_back('{addr: line * 8 + px / 16, data: model_fb[line * 8 + px / 16]});
          if (px / 16 < 7)
            exp_q.push_back('{addr: line * 8 + px / 16 + 1, data: model_fb[line * 8 + px / 16 + 1]});
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit is_draw, input bit hr, input int x, input int y,
                               input int n, input int i, output int lat);
    if (is_draw) model_draw(hr, x, y, n, i);
    else         model_clear();
    @(negedge clk);
    hires       = hr;
    x_in        = 7'(x);
    y_in        = 6'(y);
    n_in        = 4'(n);
    i_in        = 12'(i);
    start_draw  = is_draw;
    start_clear = !is_draw;
    @(negedge clk);
    start_draw  = 1'b0;
    start_clear = 1'b0;
    checkOutput("busy_rise", 32'(busy), 32'd1);
    lat = 1;
    while (!done && lat < 4000) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      checkOutput("done_timeout", 32'd0, 32'd1);
    end else begin
      done_cycle = cycle;
      checkOutput("busy_at_done", 32'(busy), 32'd1);
      checkOutput("collision", 32'(collision), 32'(exp_coll));
      @(negedge clk);
      checkOutput("done_busy_fall", 32'({done, busy}), 32'd0);
    end
    checkOutput("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int nz;
    int waited;
    res = 1'b1; hires = 1'b0; start_draw = 1'b0; start_clear = 1'b0;
    x_in = '0; y_in = '0; n_in = '0; i_in = '0;
    for (int a = 0; a < 4096; a++) spr_mem[a] = 8'($urandom);
    spr_mem[12'h200] = 8'hF0;
    spr_mem[12'h210] = 8'hFF;
    spr_mem[12'h220] = 8'h80;
    for (int a = 0; a < 4; a++) spr_mem[12'h230 + a] = 8'hFF;
    fill_fb(16'h0000);
    repeat (3) @(negedge clk);
    checkOutput("reset_ctrl", 32'({busy, done, collision, spr_rd, fb_we}), 32'd0);
    checkOutput("reset_fb_addr", 32'(fb_addr), 32'd0);
    checkOutput("reset_spr_addr", 32'(spr_addr), 32'd0);
    checkOutput("reset_fb_wdata", 32'(fb_wdata), 32'd0);
    res = 1'b0;

    $display("[TB] CLEAR over a full buffer");
    fill_fb(16'hFFFF);
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, lat);
    checkOutput("clear_done_after_511", 32'(done_cycle - last_wr_cycle), 32'd1);
    nz = 0;
    for (int a = 0; a < 512; a++) if (fb_mem[a] != 16'h0000) nz++;
    checkOutput("clear_nonzero_words", 32'(nz), 32'd0);

    $display("[TB] hires XOR draw and redraw");
    applyStimulus(1'b1, 1'b1, 0, 0, 1, 12'h200, lat);
    checkOutput("w0_first", 32'(fb_mem[0]), 32'h0000F000);
    checkOutput("coll_first", 32'(collision), 32'd0);
    applyStimulus(1'b1, 1'b1, 0, 0, 1, 12'h200, lat);
    checkOutput("w0_second", 32'(fb_mem[0]), 32'd0);
    checkOutput("coll_second", 32'(collision), 32'd1);

    $display("[TB] hires straddle, right clip, bottom clip");
    applyStimulus(1'b1, 1'b1, 12, 3, 1, 12'h210, lat);
    checkOutput("w24", 32'(fb_mem[24]), 32'h0000000F);
    checkOutput("w25", 32'(fb_mem[25]), 32'h0000F000);
    applyStimulus(1'b1, 1'b1, 124, 10, 1, 12'h210, lat);
    checkOutput("w87_clip", 32'(fb_mem[87]), 32'h0000000F);
    checkOutput("w88_untouched", 32'(fb_mem[88]), 32'd0);
    applyStimulus(1'b1, 1'b1, 0, 62, 4, 12'h230, lat);
    checkOutput("row62", 32'(fb_mem[496]), 32'h0000FF00);
    checkOutput("row63", 32'(fb_mem[504]), 32'h0000FF00);

    $display("[TB] lores draws");
    applyStimulus(1'b1, 1'b0, 0, 0, 1, 12'h220, lat);
    checkOutput("lores_w0", 32'(fb_mem[0]), 32'h0000C000);
    checkOutput("lores_w8", 32'(fb_mem[8]), 32'h0000C000);
    applyStimulus(1'b1, 1'b0, 5, 5, 0, 12'h220, lat);
    checkOutput("lores_n0_latency", 32'(lat), 32'd1);
    applyStimulus(1'b1, 1'b0, 60, 30, 3, 12'h250, lat);

    $display("[TB] wide sprite and address wrap");
    applyStimulus(1'b1, 1'b1, 5, 20, 0, 12'h240, lat);
    applyStimulus(1'b1, 1'b1, 5, 20, 0, 12'h240, lat);
    applyStimulus(1'b1, 1'b1, 100, 40, 3, 12'hFFE, lat);

    $display("[TB] reset during a multi-row draw");
    model_draw(1'b1, 30, 5, 6, 12'h260);
    @(negedge clk);
    hires = 1'b1; x_in = 7'd30; y_in = 6'd5; n_in = 4'd6; i_in = 12'h260;
    start_draw = 1'b1;
    @(negedge clk);
    start_draw = 1'b0;
    waited = 0;
    while (!fb_we && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("reached_wr0", 32'(fb_we), 32'd1);
    res = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy_we", 32'({busy, fb_we}), 32'd0);
    res = 1'b0;
    exp_q.delete();
    repeat (20) @(negedge clk);
    checkOutput("abort_stays_idle", 32'(busy), 32'd0);
    fill_fb(16'h0000);
    applyStimulus(1'b1, 1'b1, 30, 5, 6, 12'h260, lat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
